wordlit_op_stream: RTL and testbench

//   Parametrised successor to the fixed 8->16-bit "input XOR literal" block. Applies one of four

---
 rtl/wordlit_op_stream.sv | 152 +++++++++++++++
 tb/tb_wordlit_op_stream.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wordlit_op_stream.sv
// ---------------------------------------------------------------------------
// wordlit_op_stream
//   Applies one of four literal/accumulate operations to a zero-extended
//   input word and holds the result in a single output register with
//   valid/ready flow control. A sticky overflow flag records any carry or
//   borrow, and an 8-bit counter tallies accepted transactions.
//
// Parameters
//   IN_W     input data width (must not exceed OUT_W)
//   OUT_W    output/accumulator width (at most 64)
//   LIT      literal operand, truncated to OUT_W bits
//   RST_VAL  out_data value after reset, truncated to OUT_W bits
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active-low
//   in_valid   in   1      in_data/in_op valid
//   in_ready   out  1      block accepts in_data this cycle
//   in_data    in   IN_W   operand word
//   in_op      in   2      0=XOR LIT, 1=ADD LIT, 2=SUB LIT, 3=ACC (acc += in)
//   out_valid  out  1      out_data holds an unconsumed result
//   out_ready  in   1      consumer takes out_data this cycle
//   out_data   out  OUT_W  result word
//   ovf        out  1      sticky carry/borrow flag
//   count      out  8      accepted-transaction counter, wraps 255->0
// ---------------------------------------------------------------------------
module wordlit_op_stream #(
  parameter int unsigned IN_W    = 8,
  parameter int unsigned OUT_W   = 16,
  parameter logic [63:0] LIT     = 64'd1,
  parameter logic [63:0] RST_VAL = 64'hfffe
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             ovf,
  output logic [7:0]       count
);

  // Widths are checked at elaboration so a bad instance never builds.
  if (IN_W > OUT_W) begin : g_bad_in_w
    $error("wordlit_op_stream: IN_W must not exceed OUT_W");
  end
  if (OUT_W > 64) begin : g_bad_out_w
    $error("wordlit_op_stream: OUT_W must not exceed 64");
  end

  typedef enum logic [1:0] {
    OP_XOR = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2,
    OP_ACC = 2'd3
  } op_e;

  localparam logic [OUT_W-1:0] L_VAL = LIT[OUT_W-1:0];
  localparam logic [OUT_W-1:0] R_VAL = RST_VAL[OUT_W-1:0];

  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q,  out_data_d;
  logic [OUT_W-1:0] acc_q,       acc_d;
  logic             ovf_q,       ovf_d;
  logic [7:0]       count_q,     count_d;

  logic             accept;
  logic             drain;
  logic [OUT_W-1:0] a_val;
  logic [OUT_W:0]   add_ext;
  logic [OUT_W:0]   acc_ext;
  logic [OUT_W-1:0] sub_res;
  logic             borrow;

  // Single-entry output stage: room exists when empty or being drained.
  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid_q && out_ready;

  // Operand and the three arithmetic paths; the extra top bit of the
  // extended sums is the carry out of bit OUT_W-1.
  assign a_val   = OUT_W'(in_data);
  assign add_ext = {1'b0, a_val} + {1'b0, L_VAL};
  assign acc_ext = {1'b0, acc_q} + {1'b0, a_val};
  assign sub_res = a_val - L_VAL;
  assign borrow  = (a_val < L_VAL);

  // Next-state: an accept loads a new result (and wins over a concurrent
  // drain, since the slot is refilled); a lone drain only clears valid so
  // out_data keeps its last value.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    count_d     = count_q;

    if (accept) begin
      out_valid_d = 1'b1;
      count_d     = count_q + 8'd1;
      case (op_e'(in_op))
        OP_XOR: begin
          out_data_d = a_val ^ L_VAL;
        end
        OP_ADD: begin
          out_data_d = add_ext[OUT_W-1:0];
          ovf_d      = ovf_q | add_ext[OUT_W];
        end
        OP_SUB: begin
          out_data_d = sub_res;
          ovf_d      = ovf_q | borrow;
        end
        OP_ACC: begin
          out_data_d = acc_ext[OUT_W-1:0];
          acc_d      = acc_ext[OUT_W-1:0];
          ovf_d      = ovf_q | acc_ext[OUT_W];
        end
        default: begin
          out_data_d = out_data_q;
        end
      endcase
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  // State register; reset discards any in-flight result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= R_VAL;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      count_q     <= 8'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign ovf       = ovf_q;
  assign count     = count_q;

endmodule

// File: tb/tb_wordlit_op_stream.sv
// ---------------------------------------------------------------------------
// tb_wordlit_op_stream
//   Directed bench for wordlit_op_stream: a 16-bit instance driven from a
//   table of hand-computed vectors plus hand-written flow-control and reset
//   sequences, and an 8-bit instance for the wrap/carry cases.
// ---------------------------------------------------------------------------
module tb_wordlit_op_stream;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  data;
    logic [15:0] exp_data;
    logic        exp_ovf;
  } vec_t;

  localparam logic [1:0] XOR_OP = 2'd0;
  localparam logic [1:0] ADD_OP = 2'd1;
  localparam logic [1:0] SUB_OP = 2'd2;
  localparam logic [1:0] ACC_OP = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        ovf;
  logic [7:0]  count;

  logic        rst8;
  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  in_data8;
  logic [1:0]  in_op8;
  logic        out_valid8;
  logic        out_ready8;
  logic [7:0]  out_data8;
  logic        ovf8;
  logic [7:0]  count8;

  int assertions = 0;
  int failures   = 0;

  vec_t vecs[7];

  always #5 clk = ~clk;

  wordlit_op_stream #(
    .IN_W(8), .OUT_W(16), .LIT(64'd1), .RST_VAL(64'hfffe)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .ovf(ovf), .count(count)
  );

  wordlit_op_stream #(
    .IN_W(8), .OUT_W(8), .LIT(64'd1), .RST_VAL(64'hfffe)
  ) dut8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data8), .in_op(in_op8), .out_valid(out_valid8),
    .out_ready(out_ready8), .out_data(out_data8), .ovf(ovf8), .count(count8)
  );

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one transaction on the 16-bit instance and step one clock,
  // sampling 1 time unit after the edge.
  task automatic applyStimulus(input logic valid, input logic [1:0] op,
                               input logic [7:0] data);
    in_valid = valid;
    in_op    = op;
    in_data  = data;
    @(posedge clk);
    #1;
  endtask

  // Same for the 8-bit instance.
  task automatic applyStimulus8(input logic valid, input logic [1:0] op,
                                input logic [7:0] data);
    in_valid8 = valid;
    in_op8    = op;
    in_data8  = data;
    @(posedge clk);
    #1;
  endtask

  task automatic runVectors(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      applyStimulus(1'b1, vecs[i].op, vecs[i].data);
      checkOutput($sformatf("vec%0d valid", i), 64'(out_valid), 64'd1);
      checkOutput($sformatf("vec%0d data", i), 64'(out_data), 64'(vecs[i].exp_data));
      checkOutput($sformatf("vec%0d ovf", i), 64'(ovf), 64'(vecs[i].exp_ovf));
    end
    in_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{XOR_OP, 8'h05, 16'h0004, 1'b0};
    vecs[1] = '{ADD_OP, 8'hff, 16'h0100, 1'b0};
    vecs[2] = '{SUB_OP, 8'h00, 16'hffff, 1'b1};
    vecs[3] = '{XOR_OP, 8'h00, 16'h0001, 1'b1};
    vecs[4] = '{ACC_OP, 8'hff, 16'h00ff, 1'b0};
    vecs[5] = '{ACC_OP, 8'hff, 16'h01fe, 1'b0};
    vecs[6] = '{ACC_OP, 8'hff, 16'h02fd, 1'b0};

    rst = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_data = 8'h00; out_ready = 1'b1;
    rst8 = 1'b0; in_valid8 = 1'b0; in_op8 = 2'd0; in_data8 = 8'h00; out_ready8 = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst out_data", 64'(out_data), 64'hfffe);
    checkOutput("rst ovf", 64'(ovf), 64'd0);
    checkOutput("rst count", 64'(count), 64'd0);
    checkOutput("rst in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst8 out_data", 64'(out_data8), 64'hfe);
    rst = 1'b1;

    // XOR / ADD / SUB, sticky ovf through a later XOR
    runVectors(0, 3);
    checkOutput("count after 4", 64'(count), 64'd4);

    // Drain without accept: valid drops, data holds
    applyStimulus(1'b0, XOR_OP, 8'h00);
    checkOutput("drain valid", 64'(out_valid), 64'd0);
    checkOutput("drain data hold", 64'(out_data), 64'h0001);

    // Backpressure: result stalls, input held off, then same-cycle drain+accept
    out_ready = 1'b0;
    applyStimulus(1'b1, XOR_OP, 8'h10);
    checkOutput("stall first data", 64'(out_data), 64'h0011);
    in_data = 8'h20;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("stall%0d in_ready", i), 64'(in_ready), 64'd0);
      checkOutput($sformatf("stall%0d data", i), 64'(out_data), 64'h0011);
      checkOutput($sformatf("stall%0d valid", i), 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    checkOutput("release in_ready", 64'(in_ready), 64'd1);
    applyStimulus(1'b1, XOR_OP, 8'h20);
    checkOutput("release data", 64'(out_data), 64'h0021);
    checkOutput("release valid", 64'(out_valid), 64'd1);
    applyStimulus(1'b0, XOR_OP, 8'h00);
    checkOutput("count after 6", 64'(count), 64'd6);
    checkOutput("ovf still set", 64'(ovf), 64'd1);

    // Fresh reset, then accumulate
    rst = 1'b0;
    applyStimulus(1'b0, XOR_OP, 8'h00);
    rst = 1'b1;
    runVectors(4, 6);
    checkOutput("acc count", 64'(count), 64'd3);

    // Reset while a result is stalled
    out_ready = 1'b0;
    applyStimulus(1'b0, XOR_OP, 8'h00);
    checkOutput("hold valid", 64'(out_valid), 64'd1);
    checkOutput("hold data", 64'(out_data), 64'h02fd);
    rst = 1'b0;
    applyStimulus(1'b1, ACC_OP, 8'h55);
    checkOutput("mid rst valid", 64'(out_valid), 64'd0);
    checkOutput("mid rst data", 64'(out_data), 64'hfffe);
    checkOutput("mid rst ovf", 64'(ovf), 64'd0);
    checkOutput("mid rst count", 64'(count), 64'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b1, ACC_OP, 8'h00);
    checkOutput("acc cleared", 64'(out_data), 64'h0000);
    checkOutput("count 1", 64'(count), 64'd1);

    // Back-to-back accepts through the counter wrap
    for (int i = 0; i < 254; i++) begin
      applyStimulus(1'b1, XOR_OP, 8'(i));
    end
    checkOutput("count ff", 64'(count), 64'hff);
    applyStimulus(1'b1, XOR_OP, 8'h33);
    checkOutput("count wrap", 64'(count), 64'h00);
    checkOutput("wrap data", 64'(out_data), 64'h0032);
    in_valid = 1'b0;

    // 8-bit instance: accumulator and ADD carry, SUB without borrow
    rst8 = 1'b1;
    applyStimulus8(1'b1, ACC_OP, 8'hff);
    checkOutput("w8 acc1 data", 64'(out_data8), 64'hff);
    checkOutput("w8 acc1 ovf", 64'(ovf8), 64'd0);
    applyStimulus8(1'b1, ACC_OP, 8'hff);
    checkOutput("w8 acc2 data", 64'(out_data8), 64'hfe);
    checkOutput("w8 acc2 ovf", 64'(ovf8), 64'd1);
    rst8 = 1'b0;
    applyStimulus8(1'b0, XOR_OP, 8'h00);
    checkOutput("w8 rst data", 64'(out_data8), 64'hfe);
    checkOutput("w8 rst ovf", 64'(ovf8), 64'd0);
    rst8 = 1'b1;
    applyStimulus8(1'b1, ADD_OP, 8'hff);
    checkOutput("w8 add data", 64'(out_data8), 64'h00);
    checkOutput("w8 add ovf", 64'(ovf8), 64'd1);
    rst8 = 1'b0;
    applyStimulus8(1'b0, XOR_OP, 8'h00);
    rst8 = 1'b1;
    applyStimulus8(1'b1, SUB_OP, 8'h02);
    checkOutput("w8 sub data", 64'(out_data8), 64'h01);
    checkOutput("w8 sub ovf", 64'(ovf8), 64'd0);
    checkOutput("w8 count", 64'(count8), 64'd1);
    in_valid8 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
